im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Writer-side counterpart to the CPU's instruction fetch path.
- Receives a byte stream (valid/ready) from a host/debug link, packs bytes into 32-bit instruction words and writes them into the instruction memory's write port.
- Holds the CPU in stall while loading; releases it on completion.
- Sits between the host link and the IM, alongside the CPU top level.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- MAX_WORDS, 1024, largest legal word count; a larger header count is an error.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse, begins a load session
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
- im_we  output  1  IM write enable, one-cycle pulse per word
- im_addr  output  32  IM byte address, word aligned
- im_wdata  output  32  instruction word
- cpu_hold  output  1  stall request to CPU (PC must not advance)
- busy  output  1  session in progress
- done  output  1  level, session finished (success or error)
- err  output  1  level, session ended in error
- words_loaded  output  16  words written this session

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; internal byte counter, word index, shift register and checksum cleared. Reset mid-session aborts immediately; no further im_we.
- States: IDLE, HDR, DATA, WRITE, CHK (only with feature), DONE.
- IDLE/DONE: in_ready=0. start=1 -> HDR next cycle; clears done, err, words_loaded; cpu_hold=1, busy=1 from that cycle. start is ignored in HDR/DATA/WRITE/CHK.
- HDR: in_ready=1; two bytes, MSB first, form 16-bit count N.
  - N=0 -> DONE, no writes.
  - N>MAX_WORDS -> DONE with err=1, no writes.
  - Otherwise -> DATA.
- DATA: in_ready=1; 4 bytes per word, first byte = bits 31:24 (big-endian). After 4th accepted byte -> WRITE.
- WRITE (exactly 1 cycle): in_ready=0; im_we=1, im_wdata=packed word, im_addr=BASE_ADDR+4*index (32-bit wrap). Next cycle: words_loaded=index+1.
  - If index+1 < N -> DATA.
  - Otherwise -> CHK (feature) or DONE.
- Per word: minimum 5 cycles from first byte to im_we (4 accepts + WRITE). in_valid gaps stall without losing partial bytes.
- DONE entry: busy=0, cpu_hold=0, done=1 (all registered, same cycle). done and err hold until next start or reset.
- im_addr/im_wdata hold last values when im_we=0.

Optional Feature:
- Macro: IM_LOADER_CHKSUM_EN
- Defined:
  - After the last WRITE, enter CHK; accept one byte.
  - Compare it with the XOR of all data bytes (header excluded).
  - Mismatch -> err=1 in DONE. Words already written remain written.
- Undefined: no CHK state; the last WRITE goes directly to DONE; err is set only by the count check.

Test Plan:
- Reset mid-DATA after 2 bytes -> next cycle all outputs 0, state IDLE; later start + header 00 01 + DE AD BE EF -> single im_we, im_addr=0x0, im_wdata=0xDEADBEEF, words_loaded=1, done=1.
- Header 00 03 + 12 bytes, in_valid continuous -> im_we at addresses 0x0, 0x4, 0x8, each 5 cycles apart; cpu_hold high until the DONE cycle.
- Header 00 00 -> done=1, err=0, no im_we.
- Header 04 01 (1025 > MAX_WORDS) -> done=1, err=1, no im_we.
- in_valid toggled 1/0 every cycle during word 20 01 00 05 -> same im_wdata=0x20010005; in_ready=0 during WRITE; start pulsed during DATA is ignored.
- (IM_LOADER_CHKSUM_EN) 1 word 01 02 03 04 + checksum 0x04 -> err=0; checksum 0x05 -> err=1, word still written.

Source files
------------

// File: rtl/im_loader.sv
// Packs a host byte stream into 32-bit big-endian words and writes them into instruction memory while stalling the CPU.
// Optional trailing XOR checksum byte is enabled by defining IM_LOADER_CHKSUM_EN.
module im_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

`ifdef IM_LOADER_CHKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE} state_t;
`endif

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] words_q, words_d;
`ifdef IM_LOADER_CHKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif

  logic        xfer;
  logic [15:0] hdr_n;
  logic [16:0] idx_inc;

  assign hdr_n   = {shift_q[7:0], in_data};
  assign idx_inc = {1'b0, idx_q} + 17'd1;
  assign xfer    = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    words_d    = words_q;
`ifdef IM_LOADER_CHKSUM_EN
    chk_d      = chk_q;
`endif
    in_ready   = 1'b0;
    im_we      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_HDR;
          busy_d     = 1'b1;
          hold_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          words_d    = 16'd0;
          byte_cnt_d = 2'd0;
          idx_d      = 16'd0;
`ifdef IM_LOADER_CHKSUM_EN
          chk_d      = 8'd0;
`endif
        end
      end

      S_HDR: begin
        in_ready = 1'b1;
        if (xfer) begin
          if (byte_cnt_q == 2'd0) begin
            shift_d    = {shift_q[15:0], in_data};
            byte_cnt_d = 2'd1;
          end else begin
            byte_cnt_d = 2'd0;
            cnt_d      = hdr_n;
            if (hdr_n == 16'd0 || {1'b0, hdr_n} > MAX_W) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              hold_d  = 1'b0;
              done_d  = 1'b1;
              err_d   = (hdr_n != 16'd0);
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        in_ready = 1'b1;
        if (xfer) begin
          shift_d    = {shift_q[15:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IM_LOADER_CHKSUM_EN
          chk_d      = chk_q ^ in_data;
`endif
          // Address and data are captured here so they stay stable through and after the write pulse.
          if (byte_cnt_q == 2'd3) begin
            wdata_d = {shift_q, in_data};
            addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        im_we   = 1'b1;
        idx_d   = idx_inc[15:0];
        words_d = idx_inc[15:0];
        if (idx_inc < {1'b0, cnt_q}) begin
          state_d = S_DATA;
        end else begin
`ifdef IM_LOADER_CHKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
          busy_d  = 1'b0;
          hold_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end

`ifdef IM_LOADER_CHKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        if (xfer) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          hold_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = (in_data != chk_q);
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      cnt_q      <= 16'd0;
      idx_q      <= 16'd0;
      shift_q    <= 24'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      busy_q     <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= 16'd0;
`ifdef IM_LOADER_CHKSUM_EN
      chk_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      words_q    <= words_d;
`ifdef IM_LOADER_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign im_addr      = addr_q;
  assign im_wdata     = wdata_q;
  assign cpu_hold     = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: reset abort, multi-word load, empty/oversize headers, gapped input, optional checksum.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  im_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          cyc = 0;
  int          we_cnt = 0;
  logic [31:0] wa [0:15];
  logic [31:0] wd [0:15];
  int          wc [0:15];
  logic        in_session = 1'b0;
  int          hold_err = 0;
  int          rdy_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write capture and protocol watchers, sampled mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (im_we) begin
      if (we_cnt < 16) begin
        wa[we_cnt] <= im_addr;
        wd[we_cnt] <= im_wdata;
        wc[we_cnt] <= cyc;
      end
      we_cnt <= we_cnt + 1;
      if (in_ready) rdy_err <= rdy_err + 1;
    end
    if (in_session && !done && !cpu_hold) hold_err <= hold_err + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    int g;
    g = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("rdy_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    @(negedge clk);
  endtask

  task automatic send_sum(input logic [7:0] s);
`ifdef IM_LOADER_CHKSUM_EN
    send_byte(s);
`else
    in_data = s;
`endif
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_session = 1'b1;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    check({tag, "_err_clr"}, {31'd0, err}, 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int g;
    g = 0;
    while (!done && g < 100) begin
      @(negedge clk);
      g++;
    end
    in_session = 1'b0;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    check({tag, "_hold_off"}, {31'd0, cpu_hold}, 32'd0);
  endtask

  int base;

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdy", {31'd0, in_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_words", {16'd0, words_loaded}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort mid-DATA with reset, then a clean single-word load.
    do_start("t1a");
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hDE); send_byte(8'hAD);
    rst_n = 1'b0;
    in_session = 1'b0;
    @(negedge clk);
    check("t1_rst_outs", {busy, cpu_hold, done, err, in_ready, im_we}, 32'd0);
    check("t1_rst_addr", im_addr, 32'd0);
    check("t1_rst_data", im_wdata, 32'd0);
    check("t1_rst_words", {16'd0, words_loaded}, 32'd0);
    check("t1_rst_nowe", we_cnt, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_start("t1b");
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_sum(8'h22);
    wait_done("t1b");
    check("t1_we_cnt", we_cnt, 32'd1);
    check("t1_addr", wa[0], 32'h0);
    check("t1_data", wd[0], 32'hDEADBEEF);
    check("t1_words", {16'd0, words_loaded}, 32'd1);
    check("t1_err", {31'd0, err}, 32'd0);

    // Three words, continuous valid.
    base = we_cnt;
    do_start("t2");
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    send_byte(8'h99); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    send_sum(8'hCC);
    wait_done("t2");
    check("t2_we_cnt", we_cnt - base, 32'd3);
    check("t2_addr0", wa[base], 32'h0);
    check("t2_addr1", wa[base+1], 32'h4);
    check("t2_addr2", wa[base+2], 32'h8);
    check("t2_data0", wd[base], 32'h11223344);
    check("t2_data1", wd[base+1], 32'h55667788);
    check("t2_data2", wd[base+2], 32'h99AABBCC);
    check("t2_gap01", wc[base+1] - wc[base], 32'd5);
    check("t2_gap12", wc[base+2] - wc[base+1], 32'd5);
    check("t2_words", {16'd0, words_loaded}, 32'd3);
    check("t2_hold_err", hold_err, 32'd0);

    // Empty header.
    base = we_cnt;
    do_start("t3");
    send_byte(8'h00); send_byte(8'h00);
    wait_done("t3");
    check("t3_err", {31'd0, err}, 32'd0);
    check("t3_words", {16'd0, words_loaded}, 32'd0);
    repeat (3) @(negedge clk);
    check("t3_done_hold", {31'd0, done}, 32'd1);
    check("t3_no_we", we_cnt - base, 32'd0);

    // Count one beyond the limit.
    base = we_cnt;
    do_start("t4");
    send_byte(8'h04); send_byte(8'h01);
    wait_done("t4");
    check("t4_err", {31'd0, err}, 32'd1);
    repeat (3) @(negedge clk);
    check("t4_err_hold", {31'd0, err}, 32'd1);
    check("t4_no_we", we_cnt - base, 32'd0);

    // Gapped valid with a stray start pulse mid-word.
    base = we_cnt;
    do_start("t5");
    send_gap(8'h00); send_gap(8'h01);
    send_byte(8'h20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_gap(8'h01); send_gap(8'h00); send_gap(8'h05);
    send_sum(8'h24);
    wait_done("t5");
    check("t5_we_cnt", we_cnt - base, 32'd1);
    check("t5_data", wd[base], 32'h20010005);
    check("t5_addr", wa[base], 32'h0);
    check("t5_words", {16'd0, words_loaded}, 32'd1);
    check("t5_err", {31'd0, err}, 32'd0);
    check("t5_rdy_in_write", rdy_err, 32'd0);
    check("t5_hold_err", hold_err, 32'd0);
    check("t5_data_hold", im_wdata, 32'h20010005);

`ifdef IM_LOADER_CHKSUM_EN
    base = we_cnt;
    do_start("t6a");
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h04);
    wait_done("t6a");
    check("t6a_err", {31'd0, err}, 32'd0);
    check("t6a_we", we_cnt - base, 32'd1);
    base = we_cnt;
    do_start("t6b");
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05);
    wait_done("t6b");
    check("t6b_err", {31'd0, err}, 32'd1);
    check("t6b_we", we_cnt - base, 32'd1);
    check("t6b_data", wd[base], 32'h01020304);
    check("t6b_words", {16'd0, words_loaded}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
